// File: rtl/regfile_ctrl_pkg.sv
// Shared widths and write-back source encoding for the register-file write-back controller.
// Constants only; no logic, latency or flow control here.
package regfile_ctrl_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy vector of registers with a write in flight; set at issue, cleared at the register-file write edge.
// Lookups are combinational; set/clear take effect at the next clock edge; never back-pressures.
module regfile_scoreboard
  import regfile_ctrl_pkg::*;
#(
  parameter int NUM_REG = NREG
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               set_en_i,
  input  logic [REG_AW-1:0]  set_idx_i,
  input  logic               clr_en_i,
  input  logic [REG_AW-1:0]  clr_idx_i,
  input  logic [REG_AW-1:0]  rs1_idx_i,
  input  logic [REG_AW-1:0]  rs2_idx_i,
  input  logic [REG_AW-1:0]  rd_idx_i,
  output logic               rs1_busy_o,
  output logic               rs2_busy_o,
  output logic               rd_busy_o,
  output logic [NUM_REG-1:0] busy_mask_o
);

  logic [NUM_REG-1:0] busy_q;
  logic [NUM_REG-1:0] busy_d;

  // Set and clear never target the same bit: an issue to a busy rd is stalled upstream.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
    if (set_en_i) busy_d[set_idx_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rs1_busy_o  = busy_q[rs1_idx_i];
  assign rs2_busy_o  = busy_q[rs2_idx_i];
  assign rd_busy_o   = busy_q[rd_idx_i];
  assign busy_mask_o = busy_q;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Round-robin write-back arbiter (ALU/LSU) into a registered RF write port, plus RAW/WAW issue stall.
// One-cycle handshake-to-write latency; write stage never back-pressures, issue stalls on busy registers.
module regfile_wb_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int XLEN = regfile_ctrl_pkg::XLEN,
  parameter int NREG = regfile_ctrl_pkg::NREG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rs1,
  input  logic [REG_AW-1:0] issue_rs2,
  input  logic [REG_AW-1:0] issue_rd,
  output logic              issue_stall,
  input  logic              alu_wb_valid,
  input  logic [REG_AW-1:0] alu_wb_rd,
  input  logic [XLEN-1:0]   alu_wb_data,
  output logic              alu_wb_ready,
  input  logic              lsu_wb_valid,
  input  logic [REG_AW-1:0] lsu_wb_rd,
  input  logic [XLEN-1:0]   lsu_wb_data,
  output logic              lsu_wb_ready,
  output logic              rf_wr_en,
  output logic [REG_AW-1:0] rf_rd,
  output logic [XLEN-1:0]   rf_wr_data,
  output logic [NREG-1:0]   busy_mask,
  output logic              wb_unexpected
);

  logic              rs1_busy;
  logic              rs2_busy;
  logic              rd_busy;
  logic              issue_set;

  src_e              last_q;
  src_e              last_d;
  logic              grant_alu;
  logic              grant_lsu;
  logic              wb_hs;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;

  logic              rf_wr_en_q;
  logic              rf_wr_en_d;
  logic [REG_AW-1:0] rf_rd_q;
  logic [REG_AW-1:0] rf_rd_d;
  logic [XLEN-1:0]   rf_wr_data_q;
  logic [XLEN-1:0]   rf_wr_data_d;
  logic              wb_unexp_q;
  logic              wb_unexp_d;

  regfile_scoreboard #(
    .NUM_REG (NREG)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_en_i    (issue_set),
    .set_idx_i   (issue_rd),
    .clr_en_i    (rf_wr_en_q),
    .clr_idx_i   (rf_rd_q),
    .rs1_idx_i   (issue_rs1),
    .rs2_idx_i   (issue_rs2),
    .rd_idx_i    (issue_rd),
    .rs1_busy_o  (rs1_busy),
    .rs2_busy_o  (rs2_busy),
    .rd_busy_o   (rd_busy),
    .busy_mask_o (busy_mask)
  );

  // Bit 0 of the scoreboard is constant zero, so x0 operands never stall.
  assign issue_stall = issue_valid & (rs1_busy | rs2_busy | rd_busy);
  assign issue_set   = issue_valid & ~issue_stall & (issue_rd != '0);

  // On a tie the source that did not win last time is granted.
  assign grant_alu = alu_wb_valid & (~lsu_wb_valid | (last_q == SRC_LSU));
  assign grant_lsu = lsu_wb_valid & (~alu_wb_valid | (last_q == SRC_ALU));
  assign wb_hs     = grant_alu | grant_lsu;

  assign alu_wb_ready = grant_alu;
  assign lsu_wb_ready = grant_lsu;

  always_comb begin
    wb_rd        = grant_lsu ? lsu_wb_rd   : alu_wb_rd;
    wb_data      = grant_lsu ? lsu_wb_data : alu_wb_data;
    last_d       = last_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_d      = rf_rd_q;
    rf_wr_data_d = rf_wr_data_q;
    wb_unexp_d   = 1'b0;
    if (wb_hs) begin
      last_d       = grant_lsu ? SRC_LSU : SRC_ALU;
      rf_wr_en_d   = (wb_rd != '0);
      rf_rd_d      = wb_rd;
      rf_wr_data_d = wb_data;
      // Busy is sampled before any clear landing on this same edge.
      wb_unexp_d   = (wb_rd != '0) & ~busy_mask[wb_rd];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q       <= SRC_LSU;
      rf_wr_en_q   <= 1'b0;
      rf_rd_q      <= '0;
      rf_wr_data_q <= '0;
      wb_unexp_q   <= 1'b0;
    end else begin
      last_q       <= last_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_q      <= rf_rd_d;
      rf_wr_data_q <= rf_wr_data_d;
      wb_unexp_q   <= wb_unexp_d;
    end
  end

  assign rf_wr_en      = rf_wr_en_q;
  assign rf_rd         = rf_rd_q;
  assign rf_wr_data    = rf_wr_data_q;
  assign wb_unexpected = wb_unexp_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: queued expected RF writes and unexpected-write pulses,
// popped by a negedge monitor; combinational and scoreboard state checked inline.
module tb_regfile_wb_ctrl;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic [4:0]  issue_rd;
  logic        issue_stall;
  logic        alu_wb_valid;
  logic [4:0]  alu_wb_rd;
  logic [31:0] alu_wb_data;
  logic        alu_wb_ready;
  logic        lsu_wb_valid;
  logic [4:0]  lsu_wb_rd;
  logic [31:0] lsu_wb_data;
  logic        lsu_wb_ready;
  logic        rf_wr_en;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wr_data;
  logic [31:0] busy_mask;
  logic        wb_unexpected;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_wr_q[$];
  logic [4:0] exp_unexp_q[$];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  regfile_wb_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .issue_rs1     (issue_rs1),
    .issue_rs2     (issue_rs2),
    .issue_rd      (issue_rd),
    .issue_stall   (issue_stall),
    .alu_wb_valid  (alu_wb_valid),
    .alu_wb_rd     (alu_wb_rd),
    .alu_wb_data   (alu_wb_data),
    .alu_wb_ready  (alu_wb_ready),
    .lsu_wb_valid  (lsu_wb_valid),
    .lsu_wb_rd     (lsu_wb_rd),
    .lsu_wb_data   (lsu_wb_data),
    .lsu_wb_ready  (lsu_wb_ready),
    .rf_wr_en      (rf_wr_en),
    .rf_rd         (rf_rd),
    .rf_wr_data    (rf_wr_data),
    .busy_mask     (busy_mask),
    .wb_unexpected (wb_unexpected)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    issue_valid = 1'b1;
    issue_rs1   = rs1;
    issue_rs2   = rs2;
    issue_rd    = rd;
  endtask

  // Monitor: every presented RF write and every unexpected pulse must match the queued expectation.
  initial begin
    wr_t        w;
    logic [4:0] u;
    forever begin
      @(negedge clk);
      if (rst_n && rf_wr_en) begin
        if (exp_wr_q.size() == 0) begin
          chk("rf_write_unexpected_extra", {27'd0, rf_rd}, 64'hFFFF);
        end else begin
          w = exp_wr_q.pop_front();
          chk("rf_rd", {59'd0, rf_rd}, {59'd0, w.rd});
          chk("rf_wr_data", {32'd0, rf_wr_data}, {32'd0, w.data});
        end
      end
      if (rst_n && wb_unexpected) begin
        if (exp_unexp_q.size() == 0) begin
          chk("wb_unexpected_extra", {59'd0, rf_rd}, 64'hFFFF);
        end else begin
          u = exp_unexp_q.pop_front();
          chk("wb_unexpected_rd", {59'd0, rf_rd}, {59'd0, u});
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    issue_valid  = 1'b0;
    issue_rs1    = '0;
    issue_rs2    = '0;
    issue_rd     = '0;
    alu_wb_valid = 1'b0;
    alu_wb_rd    = '0;
    alu_wb_data  = '0;
    lsu_wb_valid = 1'b0;
    lsu_wb_rd    = '0;
    lsu_wb_data  = '0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Reset state with idle inputs
    chk("rst_busy_mask", {32'd0, busy_mask}, 64'd0);
    chk("rst_rf_wr_en", {63'd0, rf_wr_en}, 64'd0);
    chk("rst_rf_rd", {59'd0, rf_rd}, 64'd0);
    chk("rst_alu_ready", {63'd0, alu_wb_ready}, 64'd0);
    chk("rst_lsu_ready", {63'd0, lsu_wb_ready}, 64'd0);
    chk("rst_wb_unexpected", {63'd0, wb_unexpected}, 64'd0);

    // Issue rd=5, then stall a reader of x5 until the write edge; same-edge set of rd=9
    issue(5'd0, 5'd0, 5'd5);
    #1 chk("issue_rd5_stall", {63'd0, issue_stall}, 64'd0);
    step();
    issue(5'd5, 5'd0, 5'd0);
    #1 chk("busy_after_issue5", {32'd0, busy_mask}, 64'h20);
    chk("stall_rs1_5", {63'd0, issue_stall}, 64'd1);
    alu_wb_valid = 1'b1;
    alu_wb_rd    = 5'd5;
    alu_wb_data  = 32'hDEADBEEF;
    exp_wr_q.push_back('{rd: 5'd5, data: 32'hDEADBEEF});
    #1 chk("alu_ready_single", {63'd0, alu_wb_ready}, 64'd1);
    step();
    alu_wb_valid = 1'b0;
    #1 chk("stall_during_write", {63'd0, issue_stall}, 64'd1);
    chk("rf_wr_en_after_hs", {63'd0, rf_wr_en}, 64'd1);
    chk("busy5_still_set", {32'd0, busy_mask}, 64'h20);
    issue(5'd0, 5'd0, 5'd9);
    #1 chk("issue_rd9_stall", {63'd0, issue_stall}, 64'd0);
    step();
    issue(5'd5, 5'd0, 5'd0);
    #1 chk("busy_set9_clr5", {32'd0, busy_mask}, 64'h200);
    chk("stall_released", {63'd0, issue_stall}, 64'd1 - 64'd1);
    chk("rf_wr_en_drop", {63'd0, rf_wr_en}, 64'd0);
    chk("no_unexpected_busy_write", {63'd0, wb_unexpected}, 64'd0);
    step();
    issue_valid = 1'b0;

    // Mid-stream asynchronous reset clears busy immediately
    issue(5'd0, 5'd0, 5'd5);
    step();
    issue_valid = 1'b0;
    #1 chk("busy_before_reset", {32'd0, busy_mask}, 64'h220);
    #1 rst_n = 1'b0;
    #1 chk("busy_async_reset", {32'd0, busy_mask}, 64'd0);
    step();
    step();
    rst_n = 1'b1;
    #1 chk("rf_wr_en_after_reset", {63'd0, rf_wr_en}, 64'd0);

    // Pre-issue rd 1..4, then x0-only issue must not stall or change busy
    for (int r = 1; r <= 4; r++) begin
      issue(5'd0, 5'd0, r[4:0]);
      step();
    end
    issue(5'd0, 5'd0, 5'd0);
    #1 chk("x0_issue_stall", {63'd0, issue_stall}, 64'd0);
    step();
    issue_valid = 1'b0;
    #1 chk("busy_after_x0_issue", {32'd0, busy_mask}, 64'h1E);

    // Round-robin contention: expected write order 1,3,2,4
    exp_wr_q.push_back('{rd: 5'd1, data: 32'h11111111});
    exp_wr_q.push_back('{rd: 5'd3, data: 32'h33333333});
    exp_wr_q.push_back('{rd: 5'd2, data: 32'h22222222});
    exp_wr_q.push_back('{rd: 5'd4, data: 32'h44444444});
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd1; alu_wb_data = 32'h11111111;
    lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd3; lsu_wb_data = 32'h33333333;
    #1 chk("rr0_alu_ready", {62'd0, alu_wb_ready, lsu_wb_ready}, 64'b10);
    step();
    alu_wb_rd = 5'd2; alu_wb_data = 32'h22222222;
    #1 chk("rr1_lsu_ready", {62'd0, alu_wb_ready, lsu_wb_ready}, 64'b01);
    step();
    lsu_wb_rd = 5'd4; lsu_wb_data = 32'h44444444;
    #1 chk("rr2_alu_ready", {62'd0, alu_wb_ready, lsu_wb_ready}, 64'b10);
    step();
    alu_wb_valid = 1'b0;
    #1 chk("rr3_lsu_ready", {62'd0, alu_wb_ready, lsu_wb_ready}, 64'b01);
    step();
    lsu_wb_valid = 1'b0;
    step();
    #1 chk("busy_after_rr", {32'd0, busy_mask}, 64'd0);

    // LSU write to x0: handshake, no write, no pulse
    lsu_wb_valid = 1'b1; lsu_wb_rd = 5'd0; lsu_wb_data = 32'h55555555;
    #1 chk("lsu_x0_ready", {63'd0, lsu_wb_ready}, 64'd1);
    step();
    lsu_wb_valid = 1'b0;
    #1 chk("x0_no_write", {63'd0, rf_wr_en}, 64'd0);
    chk("x0_no_unexpected", {63'd0, wb_unexpected}, 64'd0);

    // ALU write to non-busy x7: write proceeds, one-cycle unexpected pulse
    alu_wb_valid = 1'b1; alu_wb_rd = 5'd7; alu_wb_data = 32'h77777777;
    exp_wr_q.push_back('{rd: 5'd7, data: 32'h77777777});
    exp_unexp_q.push_back(5'd7);
    step();
    alu_wb_valid = 1'b0;
    #1 chk("unexpected_pulse", {63'd0, wb_unexpected}, 64'd1);
    step();
    #1 chk("unexpected_one_cycle", {63'd0, wb_unexpected}, 64'd0);
    chk("busy_after_x7", {32'd0, busy_mask}, 64'd0);
    step();
    step();

    chk("pending_writes", 64'(exp_wr_q.size()), 64'd0);
    chk("pending_unexpected", 64'(exp_unexp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
